// File: rtl/conv_accel_feeder.sv
// Host-side feeder for the convolution accelerator: loads one job of operand words
// into the accelerator FIFO, starts the compute, waits for the sum and hands it downstream.
module conv_accel_feeder #(
  parameter int BIT_LENGTH     = 16,
  parameter int WORD_COUNT     = 9,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  go,
  output logic                  busy,
  input  logic [BIT_LENGTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [BIT_LENGTH-1:0] dataInput,
  output logic                  wr_clk,
  output logic                  cStart,
  input  logic                  cReady,
  input  logic                  FULL,
  input  logic                  EMPTY,
  input  logic [BIT_LENGTH-1:0] finalsum,
  output logic [BIT_LENGTH-1:0] result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam logic [7:0]  WORDS        = 8'(WORD_COUNT);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      stateR;
  logic [7:0]  wordCntR;
  logic [15:0] waitCntR;
  logic        handshakeS;
  logic        unusedEmpty;

  // The accelerator copes with an empty FIFO on start, so EMPTY carries no decision here.
  assign unusedEmpty = EMPTY;

  // The write-strobe gap gives FULL one cycle to reflect the previous write.
  assign busy       = (stateR != IDLE);
  assign s_ready    = (stateR == LOAD) && !FULL && !wr_clk && (wordCntR < WORDS);
  assign handshakeS = s_valid && s_ready;

  // Job sequencer: load words, pulse start, wait for the sum, hold it for downstream.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stateR       <= IDLE;
      wordCntR     <= 8'd0;
      waitCntR     <= 16'd0;
      dataInput    <= '0;
      wr_clk       <= 1'b0;
      cStart       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      wr_clk <= 1'b0;
      cStart <= 1'b0;
      case (stateR)
        IDLE: begin
          if (go) begin
            stateR   <= LOAD;
            wordCntR <= 8'd0;
            err      <= 1'b0;
          end
        end
        LOAD: begin
          if (handshakeS) begin
            dataInput <= s_data;
            wr_clk    <= 1'b1;
            wordCntR  <= wordCntR + 8'd1;
          end else if (wordCntR >= WORDS) begin
            // The last strobe is dropping on this edge, so start follows it directly.
            stateR <= START;
            cStart <= 1'b1;
          end
        end
        START: begin
          stateR   <= WAIT;
          waitCntR <= 16'd0;
        end
        WAIT: begin
          if (cReady) begin
            result       <= finalsum;
            result_valid <= 1'b1;
            stateR       <= HOLD;
          end else if (waitCntR >= TIMEOUT_LAST) begin
            err    <= 1'b1;
            stateR <= IDLE;
          end else begin
            waitCntR <= waitCntR + 16'd1;
          end
        end
        HOLD: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            stateR       <= IDLE;
          end
        end
        default: begin
          stateR <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_accel_feeder.sv
// Randomized scoreboard bench for conv_accel_feeder with a behavioural accelerator model.
module tb_conv_accel_feeder;
  localparam int BL = 16;
  localparam int WC = 9;
  localparam int TO = 32;

  logic          Clk = 1'b0;
  logic          Rst, go, s_valid, FULL, EMPTY, result_ready;
  logic          cReady = 1'b0;
  logic [BL-1:0] s_data;
  logic [BL-1:0] finalsum = '0;
  logic          busy, s_ready, wr_clk, cStart, result_valid, err;
  logic [BL-1:0] dataInput, result;

  int total = 0;
  int bad   = 0;
  logic [BL-1:0] expWords[$];
  logic [BL-1:0] expResults[$];
  int  spacingCheck = 0;
  int  lat = 20;

  always #5 Clk = ~Clk;

  conv_accel_feeder #(.BIT_LENGTH(BL), .WORD_COUNT(WC), .TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Rst(Rst), .go(go), .busy(busy),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dataInput(dataInput), .wr_clk(wr_clk), .cStart(cStart),
    .cReady(cReady), .FULL(FULL), .EMPTY(EMPTY), .finalsum(finalsum),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor + accelerator model, sampled mid-cycle after the falling edge.
  logic          prevWr = 1'b0, prevFull = 1'b0, prevValid = 1'b0, prevErr = 1'b0;
  logic [BL-1:0] prevResult = '0;
  logic [BL-1:0] accSum = '0, capSum = '0;
  int gap = 0, sinceStart = 0, down = -1;

  always begin
    @(negedge Clk);
    #2;
    if (!Rst) begin
      accSum = '0; down = -1; cReady = 1'b0; gap = 0;
      prevWr = 1'b0; prevValid = 1'b0; prevErr = 1'b0; prevFull = 1'b0;
    end else begin
      if (FULL) check("s_ready_while_full", s_ready, 1'b0);
      if (wr_clk) begin
        if (expWords.size() == 0) check("wr_unexpected", 1'b1, 1'b0);
        else check("wr_data", dataInput, expWords.pop_front());
        check("wr_after_full", prevFull, 1'b0);
        check("wr_back_to_back", prevWr, 1'b0);
        if (spacingCheck != 0 && gap != 0) check("wr_spacing", gap, 2);
        accSum = accSum + dataInput;
        gap = 1;
      end else if (gap != 0) begin
        gap++;
      end
      if (down > 0) down--;
      else if (down == 0) begin
        cReady = 1'b1; finalsum = capSum; down = -1;
      end
      if (!cReady) finalsum = BL'($urandom);
      sinceStart++;
      if (cStart) begin
        check("cstart_after_last_wr", prevWr, 1'b1);
        check("cstart_wr_overlap", wr_clk, 1'b0);
        check("cstart_words_pending", expWords.size(), 0);
        capSum = accSum; accSum = '0; down = lat; sinceStart = 0; gap = 0;
      end
      if (err && !prevErr) check("timeout_cycles", sinceStart, TO + 1);
      if (result_valid && !prevValid) begin
        if (expResults.size() == 0) check("result_unexpected", 1'b1, 1'b0);
        else check("result_value", result, expResults.pop_front());
        cReady = 1'b0;
      end else if (result_valid) begin
        check("result_stable", result, prevResult);
      end
      prevWr = wr_clk; prevFull = FULL; prevValid = result_valid;
      prevResult = result; prevErr = err;
    end
  end

  task automatic checkAllZero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_s_ready"}, s_ready, 1'b0);
    check({tag, "_dataInput"}, dataInput, '0);
    check({tag, "_wr_clk"}, wr_clk, 1'b0);
    check({tag, "_cStart"}, cStart, 1'b0);
    check({tag, "_result"}, result, '0);
    check({tag, "_result_valid"}, result_valid, 1'b0);
    check({tag, "_err"}, err, 1'b0);
  endtask

  // One job: fullAt/abortAt < 0 disable; latency < 0 means the accelerator never answers.
  task automatic runJob(input int fullAt, input int abortAt, input int latency,
                        input bit isSteady, input bit stallHold, input bit seq);
    logic [BL-1:0] sum = '0;
    logic [BL-1:0] w;
    int sent = 0, guard = 0, fullLeft = 0;
    lat = latency;
    spacingCheck = (isSteady && fullAt < 0) ? 1 : 0;
    EMPTY = 1'($urandom);
    @(negedge Clk); go = 1'b1;
    @(negedge Clk); go = 1'b0; #1;
    check("busy_after_go", busy, 1'b1);
    check("err_cleared_by_go", err, 1'b0);
    while (sent < WC && guard < 2000) begin
      if (fullLeft > 0) begin FULL = 1'b1; fullLeft--; end
      else FULL = 1'b0;
      if (sent == abortAt) begin
        Rst = 1'b0; #1;
        checkAllZero("abort");
        expWords.delete();
        s_valid = 1'b0; FULL = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        return;
      end
      s_valid = isSteady ? 1'b1 : ($urandom_range(0, 3) != 0);
      w = seq ? BL'(sent + 1) : BL'($urandom);
      s_data = w;
      #1;
      if (s_valid && s_ready) begin
        expWords.push_back(w);
        sum = sum + w;
        sent++;
        if (sent == fullAt) fullLeft = 10;
      end
      @(negedge Clk);
      guard++;
    end
    if (guard >= 2000) check("load_bound", 1'b1, 1'b0);
    s_valid = 1'b0; FULL = 1'b0;
    if (latency >= 0) expResults.push_back(sum);
    guard = 0;
    if (latency < 0) begin
      while (!err && guard < 500) begin @(negedge Clk); #1; guard++; end
      check("timeout_err", err, 1'b1);
      check("timeout_busy", busy, 1'b0);
      check("timeout_no_result", result_valid, 1'b0);
    end else begin
      while (!result_valid && guard < 500) begin @(negedge Clk); #1; guard++; end
      check("result_arrived", result_valid, 1'b1);
      check("hold_busy", busy, 1'b1);
      if (stallHold) begin
        for (int i = 0; i < 50; i++) begin
          @(negedge Clk);
          go = (i == 10);
          #1;
          check("stall_valid", result_valid, 1'b1);
          check("stall_busy", busy, 1'b1);
        end
        go = 1'b0;
      end
      @(negedge Clk); result_ready = 1'b1;
      @(negedge Clk); result_ready = 1'b0; #1;
      check("release_valid", result_valid, 1'b0);
      check("release_busy", busy, 1'b0);
    end
  endtask

  initial begin
    Rst = 1'b0; go = 1'b0; s_valid = 1'b0; s_data = '0;
    FULL = 1'b0; EMPTY = 1'b0; result_ready = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    checkAllZero("reset");
    @(posedge Clk); #3;
    Rst = 1'b1;
    runJob(-1, -1, 20, 1'b1, 1'b0, 1'b1);
    runJob(4, -1, 20, 1'b1, 1'b0, 1'b0);
    runJob(-1, -1, -1, 1'b0, 1'b0, 1'b0);
    runJob(-1, -1, 15, 1'b0, 1'b1, 1'b0);
    runJob(-1, 5, 20, 1'b1, 1'b0, 1'b1);
    runJob(-1, -1, 5, 1'b1, 1'b0, 1'b1);
    for (int j = 0; j < 5; j++) begin
      runJob(($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 8)) : -1, -1,
             int'($urandom_range(1, 25)), 1'b0, 1'b0, 1'b0);
    end
    repeat (3) @(negedge Clk);
    check("words_left", expWords.size(), 0);
    check("results_left", expResults.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
